// File: rtl/bidir_shift_rx.sv
// -----------------------------------------------------------------------------
// bidir_shift_rx
//
// Serial-in / parallel-out frame receiver. It collects WIDTH-bit frames from a
// qualified serial stream, either LSB-first or MSB-first, and presents each
// completed word on a valid/ready output. The shift register is separate from
// the output holding register. This lets the next frame arrive while the
// previous word is still waiting to be consumed.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   ser_in       serial data bit
//   ser_valid    ser_in carries a valid bit this cycle
//   frame_start  marks the first bit of a frame (only meaningful with ser_valid)
//   shift_dir    0 = LSB-first, 1 = MSB-first; sampled on the first bit only
//   data_out     assembled word (holding register)
//   data_valid   data_out holds an unconsumed word
//   data_ready   consumer accepts data_out while data_valid is high
//   bit_cnt      bits accepted so far in the current frame
//   busy         a frame is being received
//   overrun      sticky flag: a completed word was dropped
//   clr_overrun  synchronous clear of overrun (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module bidir_shift_rx #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frame_start,
    input  logic             shift_dir,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic [CW-1:0]    bit_cnt,
    output logic             busy,
    output logic             overrun,
    input  logic             clr_overrun
);

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             dvalid_q, dvalid_d;
    logic             ovr_q, ovr_d;

    logic             accept;
    logic             dir_eff;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt_inc;

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        dvalid_d = dvalid_q;
        ovr_d    = ovr_q;

        // A frame_start bit is accepted in any state. This also covers a
        // restart in RECV, which silently drops the partial frame.
        accept  = ser_valid && (frame_start || (state_q == RECV));

        // The first bit of a frame must already use the new direction.
        // Later bits use the latched direction, so mid-frame changes to
        // shift_dir have no effect.
        dir_eff = frame_start ? shift_dir : dir_q;
        shifted = dir_eff ? {sr_q[WIDTH-2:0], ser_in}
                          : {ser_in, sr_q[WIDTH-1:1]};
        cnt_inc = frame_start ? CW'(1) : cnt_q + CW'(1);

        if (clr_overrun) begin
            ovr_d = 1'b0;
        end
        if (dvalid_q && data_ready) begin
            dvalid_d = 1'b0;
        end

        if (accept) begin
            // On a restart, stale bits stay in sr_q. They are shifted out
            // before the new frame completes.
            sr_d = shifted;
            if (frame_start) begin
                dir_d = shift_dir;
            end
            if (cnt_inc == CW'(WIDTH)) begin
                cnt_d   = '0;
                state_d = IDLE;
                // A word being consumed this cycle frees the holding register
                // for the new one. Otherwise the new word is lost and flagged.
                // The set is assigned last, so it overrides clr_overrun.
                if (!dvalid_q || data_ready) begin
                    dout_d   = shifted;
                    dvalid_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                cnt_d   = cnt_inc;
                state_d = RECV;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sr_q     <= '0;
            dout_q   <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            dvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            dout_q   <= dout_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            dvalid_q <= dvalid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign data_out   = dout_q;
    assign data_valid = dvalid_q;
    assign bit_cnt    = cnt_q;
    assign busy       = (state_q == RECV);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_bidir_shift_rx.sv
module tb_bidir_shift_rx;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk;
    logic             reset;
    logic             ser_in;
    logic             ser_valid;
    logic             frame_start;
    logic             shift_dir;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic [CW-1:0]    bit_cnt;
    logic             busy;
    logic             overrun;
    logic             clr_overrun;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    bidir_shift_rx #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ser_in      (ser_in),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .shift_dir   (shift_dir),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .bit_cnt     (bit_cnt),
        .busy        (busy),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake consumes the oldest expected word.
    always @(negedge clk) begin
        if (reset && data_valid && data_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", data_out);
            end else begin
                logic [WIDTH-1:0] e;
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL word: got %0h expected %0h", data_out, e);
                end
            end
        end
    end

    // One serial bit: present the inputs, let one rising edge take them,
    // then return to idle inputs 1 ns after that edge.
    task automatic sbit(input logic b, input logic fs, input logic dir);
        ser_in      = b;
        frame_start = fs;
        shift_dir   = dir;
        ser_valid   = 1'b1;
        @(posedge clk);
        #1;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; frame_start = 1'b0;
        shift_dir = 1'b0; data_ready = 1'b0; clr_overrun = 1'b0;
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_bit_cnt", bit_cnt, 0);
        chk("rst_overrun", overrun, 0);
        #20 reset = 1'b1;
        idle(2);

        // LSB-first 0,1,0,1 gives 4'b1010.
        data_ready = 1'b1;
        exp_q.push_back(4'hA);
        sbit(0, 1, 0);
        chk("t1_bit_cnt1", bit_cnt, 1);
        chk("t1_busy1", busy, 1);
        sbit(1, 0, 0); sbit(0, 0, 0); sbit(1, 0, 0);
        chk("t1_valid", data_valid, 1);
        chk("t1_busy_done", busy, 0);
        chk("t1_bit_cnt_done", bit_cnt, 0);
        idle(2);

        // MSB-first 1,0,1,1 gives 4'b1011. shift_dir toggles after bit 1.
        exp_q.push_back(4'hB);
        sbit(1, 1, 1); sbit(0, 0, 0); sbit(1, 0, 0); sbit(1, 0, 0);
        chk("t2_data", data_out, 4'hB);
        idle(2);

        // Second word is dropped while the first waits.
        data_ready = 1'b0;
        exp_q.push_back(4'hA);
        sbit(0, 1, 0); sbit(1, 0, 0); sbit(0, 0, 0); sbit(1, 0, 0);
        sbit(1, 1, 0); sbit(0, 0, 0); sbit(1, 0, 0); sbit(0, 0, 0);
        chk("t3_data_held", data_out, 4'hA);
        chk("t3_valid_held", data_valid, 1);
        chk("t3_overrun", overrun, 1);
        data_ready = 1'b1; clr_overrun = 1'b1;
        idle(1);
        clr_overrun = 1'b0;
        chk("t3_valid_fall", data_valid, 0);
        chk("t3_overrun_clr", overrun, 0);

        // Completion in the same cycle the old word is consumed.
        data_ready = 1'b0;
        exp_q.push_back(4'h3);
        sbit(1, 1, 0); sbit(1, 0, 0); sbit(0, 0, 0); sbit(0, 0, 0);
        exp_q.push_back(4'hC);
        sbit(0, 1, 0); sbit(0, 0, 0); sbit(1, 0, 0);
        data_ready = 1'b1;
        sbit(1, 0, 0);
        chk("t4_valid", data_valid, 1);
        chk("t4_data", data_out, 4'hC);
        chk("t4_overrun", overrun, 0);
        idle(2);

        // Restart after two bits of a partial frame.
        exp_q.push_back(4'hF);
        sbit(0, 1, 0); sbit(0, 0, 0);
        sbit(1, 1, 0);
        chk("t5_restart_cnt", bit_cnt, 1);
        sbit(1, 0, 0); sbit(1, 0, 0); sbit(1, 0, 0);
        chk("t5_data", data_out, 4'hF);
        idle(2);

        // A stray bit, gaps mid-frame, then asynchronous reset after bit 3.
        ser_in = 1'b1; frame_start = 1'b0; ser_valid = 1'b1;
        idle(1);
        ser_valid = 1'b0;
        chk("t6_stray_busy", busy, 0);
        chk("t6_stray_cnt", bit_cnt, 0);
        sbit(1, 1, 0);
        idle(2);
        chk("t6_gap_cnt", bit_cnt, 1);
        sbit(0, 0, 0);
        idle(1);
        sbit(1, 0, 0);
        chk("t6_cnt3", bit_cnt, 3);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_cnt", bit_cnt, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_data", data_out, 0);
        idle(1);
        reset = 1'b1;
        idle(1);
        exp_q.push_back(4'h9);
        sbit(1, 1, 1); sbit(0, 0, 1); sbit(0, 0, 1); sbit(1, 0, 1);
        chk("t6_post_reset", data_out, 4'h9);
        idle(3);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
